// File: rtl/spi_reg_bank_if.sv
// Byte-level bus between the SPI slave shifter and the register bank.
// The master side is the SPI slave shifter; the slave side is spi_reg_bank.
interface spi_reg_bank_if #(
    parameter int NUM_REGS = 8
);
    logic                  frame_active;
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic [7:0]            tx_byte;
    logic [NUM_REGS*8-1:0] reg_out;
    logic                  wr_strobe;
    logic [6:0]            wr_addr;
    logic [7:0]            err_count;

    modport master (
        output frame_active, rx_valid, rx_byte,
        input  tx_byte, reg_out, wr_strobe, wr_addr, err_count
    );

    modport slave (
        input  frame_active, rx_valid, rx_byte,
        output tx_byte, reg_out, wr_strobe, wr_addr, err_count
    );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI byte-level register bank: command/address decode, register read/write, MISO byte return.
// Define SPI_REG_AUTOINC_EN to advance the address after each data byte (burst access with wrap).
// state | meaning: IDLE wait CS rise | CMD decode cmd byte | DATA read/write bytes | ERR reject frame
module spi_reg_bank #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input logic           clk,
    input logic           rst,
    spi_reg_bank_if.slave bus
);
    localparam int         AW         = $clog2(NUM_REGS);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, CMD, DATA, ERR} state_t;

    state_t          state_q, state_d;
    logic            frame_active_q, frame_active_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      regs_d [NUM_REGS];
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [6:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      err_count_q, err_count_d;
    logic [7:0]      err_count_inc;
    logic            frame_rise;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
`ifdef SPI_REG_AUTOINC_EN
        return a + AW'(1);
`else
        return a;
`endif
    endfunction

    assign frame_rise    = bus.frame_active & ~frame_active_q;
    assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    always_comb begin
        state_d        = state_q;
        frame_active_d = bus.frame_active;
        rw_d           = rw_q;
        addr_d         = addr_q;
        regs_d         = regs_q;
        tx_byte_d      = tx_byte_q;
        wr_strobe_d    = 1'b0;
        wr_addr_d      = wr_addr_q;
        err_count_d    = err_count_q;

        // Frame end wins over a coincident rx_valid.
        if (!bus.frame_active) begin
            state_d   = IDLE;
            tx_byte_d = 8'h00;
            addr_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_rise) state_d = CMD;
                end
                CMD: begin
                    if (bus.rx_valid) begin
                        rw_d = bus.rx_byte[7];
                        if ({1'b0, bus.rx_byte[6:0]} >= NUM_REGS_B) begin
                            state_d     = ERR;
                            tx_byte_d   = 8'hEE;
                            err_count_d = err_count_inc;
                        end else begin
                            state_d   = DATA;
                            addr_d    = bus.rx_byte[AW-1:0];
                            tx_byte_d = bus.rx_byte[7] ? 8'h00 : regs_q[bus.rx_byte[AW-1:0]];
                        end
                    end
                end
                DATA: begin
                    if (bus.rx_valid) begin
                        addr_d = next_addr(addr_q);
                        if (rw_q) begin
                            tx_byte_d = bus.rx_byte;
                            if (addr_q != '0) begin
                                regs_d[addr_q] = bus.rx_byte;
                                wr_strobe_d    = 1'b1;
                                wr_addr_d      = 7'(addr_q);
                            end else begin
                                err_count_d = err_count_inc;
                            end
                        end else begin
                            tx_byte_d = regs_q[next_addr(addr_q)];
                        end
                    end
                end
                ERR: begin
                    tx_byte_d = 8'hEE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // frame_active_q resets high so a frame already running at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            frame_active_q <= 1'b1;
            rw_q           <= 1'b0;
            addr_q         <= '0;
            tx_byte_q      <= 8'h00;
            wr_strobe_q    <= 1'b0;
            wr_addr_q      <= 7'd0;
            err_count_q    <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? ID_VALUE : 8'h00;
            end
        end else begin
            state_q        <= state_d;
            frame_active_q <= frame_active_d;
            rw_q           <= rw_d;
            addr_q         <= addr_d;
            tx_byte_q      <= tx_byte_d;
            wr_strobe_q    <= wr_strobe_d;
            wr_addr_q      <= wr_addr_d;
            err_count_q    <= err_count_d;
            regs_q         <= regs_d;
        end
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.err_count = err_count_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign bus.reg_out[8*g +: 8] = regs_q[g];
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank (NUM_REGS=8); expected MISO bytes go through a scoreboard queue.
module tb_spi_reg_bank;
    localparam logic [63:0] RST_REGS = 64'h00000000_000000A5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_bank_if #(.NUM_REGS(8)) bus_if ();

    spi_reg_bank #(.NUM_REGS(8), .ID_VALUE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_tx;
    logic [7:0] obs_tx;
    logic       obs_stb;
    logic       obs_stb_next;
    logic [7:0] exp_err;

    function automatic logic [7:0] reg_of(input int i);
        return bus_if.reg_out[8*i +: 8];
    endfunction

    // Drive one byte, record the expected response, sample tx/strobe one and two clocks later.
    task automatic xfer(input logic [7:0] b, input logic [7:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_byte  = b;
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
        obs_tx  = bus_if.tx_byte;
        obs_stb = bus_if.wr_strobe;
        @(posedge clk); #1;
        obs_stb_next = bus_if.wr_strobe;
    endtask

    task automatic frame_start();
        @(negedge clk);
        bus_if.frame_active = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic frame_end();
        @(negedge clk);
        bus_if.frame_active = 1'b0;
        @(posedge clk); #1;
        obs_tx = bus_if.tx_byte;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [7:0] bytes [4] = '{8'h81, 8'h55, 8'h81, 8'h55};
        logic [7:0] txs   [4] = '{8'h00, 8'h00, 8'h00, 8'h55};
        logic       stbs  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        bus_if.frame_active = 1'b1;
        bus_if.rx_valid     = 1'b0;
        bus_if.rx_byte      = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (bus_if.tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx got %h exp 00", bus_if.tx_byte); end
        n_tests++; if (bus_if.wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b exp 0", bus_if.wr_strobe); end
        n_tests++; if (bus_if.wr_addr !== 7'd0) begin n_fail++; $display("FAIL reset_wr_addr got %h exp 0", bus_if.wr_addr); end
        n_tests++; if (bus_if.err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err got %h exp 00", bus_if.err_count); end
        n_tests++; if (bus_if.reg_out !== RST_REGS) begin n_fail++; $display("FAIL reset_regs got %h exp %h", bus_if.reg_out, RST_REGS); end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                n_tests++; if (bus_if.reg_out !== RST_REGS) begin n_fail++; $display("FAIL stale_frame_regs got %h exp %h", bus_if.reg_out, RST_REGS); end
                n_tests++; if (bus_if.err_count !== 8'h00) begin n_fail++; $display("FAIL stale_frame_err got %h exp 00", bus_if.err_count); end
                frame_end();
                frame_start();
            end
            xfer(bytes[i], txs[i]);
            exp_tx = exp_q.pop_front();
            n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL reset_tx_%0d got %h exp %h", i, obs_tx, exp_tx); end
            n_tests++; if (obs_stb !== stbs[i]) begin n_fail++; $display("FAIL reset_stb_%0d got %b exp %b", i, obs_stb, stbs[i]); end
            n_tests++; if (obs_stb_next !== 1'b0) begin n_fail++; $display("FAIL reset_stb_width_%0d got %b exp 0", i, obs_stb_next); end
        end
        n_tests++; if (bus_if.wr_addr !== 7'd1) begin n_fail++; $display("FAIL first_write_addr got %h exp 01", bus_if.wr_addr); end
        n_tests++; if (reg_of(1) !== 8'h55) begin n_fail++; $display("FAIL first_write_reg1 got %h exp 55", reg_of(1)); end
        frame_end();
    endtask

    task automatic test_burst_read();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] rd_exp [4];
        for (int k = 0; k < 3; k++) begin
            frame_start();
            xfer(8'h82 + 8'(k), 8'h00);
            exp_tx = exp_q.pop_front();
            n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL setup_cmd_%0d got %h exp %h", k, obs_tx, exp_tx); end
            xfer(vals[k], vals[k]);
            exp_tx = exp_q.pop_front();
            n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL setup_echo_%0d got %h exp %h", k, obs_tx, exp_tx); end
            frame_end();
        end
        rd_exp = AUTOINC ? '{8'h11, 8'h22, 8'h33, 8'h00} : '{8'h11, 8'h11, 8'h11, 8'h11};
        frame_start();
        for (int i = 0; i < 4; i++) begin
            xfer((i == 0) ? 8'h02 : 8'h00, rd_exp[i]);
            exp_tx = exp_q.pop_front();
            n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL burst_read_%0d got %h exp %h", i, obs_tx, exp_tx); end
            n_tests++; if (obs_stb !== 1'b0) begin n_fail++; $display("FAIL burst_read_stb_%0d got %b exp 0", i, obs_stb); end
        end
        frame_end();
        n_tests++; if (obs_tx !== 8'h00) begin n_fail++; $display("FAIL burst_end_tx got %h exp 00", obs_tx); end
    endtask

    task automatic test_wrap_reg0();
        logic [7:0] bytes [3] = '{8'h87, 8'hAA, 8'hBB};
        logic [7:0] txs   [3] = '{8'h00, 8'hAA, 8'hBB};
        logic       stbs  [3];
        stbs = '{1'b0, 1'b1, !AUTOINC};
        frame_start();
        for (int i = 0; i < 3; i++) begin
            xfer(bytes[i], txs[i]);
            exp_tx = exp_q.pop_front();
            n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL wrap_tx_%0d got %h exp %h", i, obs_tx, exp_tx); end
            n_tests++; if (obs_stb !== stbs[i]) begin n_fail++; $display("FAIL wrap_stb_%0d got %b exp %b", i, obs_stb, stbs[i]); end
        end
        if (AUTOINC) exp_err = exp_err + 8'd1;
        n_tests++; if (reg_of(7) !== (AUTOINC ? 8'hAA : 8'hBB)) begin n_fail++; $display("FAIL wrap_reg7 got %h exp %h", reg_of(7), AUTOINC ? 8'hAA : 8'hBB); end
        n_tests++; if (reg_of(0) !== 8'hA5) begin n_fail++; $display("FAIL wrap_reg0 got %h exp a5", reg_of(0)); end
        n_tests++; if (bus_if.err_count !== exp_err) begin n_fail++; $display("FAIL wrap_err got %h exp %h", bus_if.err_count, exp_err); end
        n_tests++; if (bus_if.wr_addr !== 7'd7) begin n_fail++; $display("FAIL wrap_wr_addr got %h exp 07", bus_if.wr_addr); end
        frame_end();
    endtask

    task automatic test_err_frame();
        logic [7:0] bytes [3] = '{8'h7F, 8'h81, 8'h12};
        frame_start();
        for (int i = 0; i < 3; i++) begin
            xfer(bytes[i], 8'hEE);
            exp_tx = exp_q.pop_front();
            n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL err_tx_%0d got %h exp %h", i, obs_tx, exp_tx); end
            n_tests++; if (obs_stb !== 1'b0) begin n_fail++; $display("FAIL err_stb_%0d got %b exp 0", i, obs_stb); end
        end
        exp_err = exp_err + 8'd1;
        n_tests++; if (bus_if.err_count !== exp_err) begin n_fail++; $display("FAIL err_count got %h exp %h", bus_if.err_count, exp_err); end
        n_tests++; if (reg_of(1) !== 8'h55) begin n_fail++; $display("FAIL err_reg1 got %h exp 55", reg_of(1)); end
        frame_end();
        n_tests++; if (obs_tx !== 8'h00) begin n_fail++; $display("FAIL err_end_tx got %h exp 00", obs_tx); end
        for (int f = 0; f < 256; f++) begin
            frame_start();
            xfer(8'h7F, 8'hEE);
            exp_tx = exp_q.pop_front();
            n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL sat_tx_%0d got %h exp %h", f, obs_tx, exp_tx); end
            frame_end();
        end
        n_tests++; if (bus_if.err_count !== 8'hFF) begin n_fail++; $display("FAIL err_saturate got %h exp ff", bus_if.err_count); end
    endtask

    task automatic test_frame_end_collision();
        frame_start();
        xfer(8'h81, 8'h00);
        exp_tx = exp_q.pop_front();
        n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL coll_cmd_tx got %h exp %h", obs_tx, exp_tx); end
        @(negedge clk);
        bus_if.frame_active = 1'b0;
        bus_if.rx_valid     = 1'b1;
        bus_if.rx_byte      = 8'h77;
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
        n_tests++; if (bus_if.tx_byte !== 8'h00) begin n_fail++; $display("FAIL coll_tx got %h exp 00", bus_if.tx_byte); end
        n_tests++; if (bus_if.wr_strobe !== 1'b0) begin n_fail++; $display("FAIL coll_stb got %b exp 0", bus_if.wr_strobe); end
        n_tests++; if (reg_of(1) !== 8'h55) begin n_fail++; $display("FAIL coll_reg1 got %h exp 55", reg_of(1)); end
        @(posedge clk); #1;
        n_tests++; if (bus_if.wr_strobe !== 1'b0) begin n_fail++; $display("FAIL coll_stb_late got %b exp 0", bus_if.wr_strobe); end
    endtask

    task automatic test_rst_midburst();
        frame_start();
        xfer(8'h81, 8'h00);
        exp_tx = exp_q.pop_front();
        n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL mid_cmd_tx got %h exp %h", obs_tx, exp_tx); end
        xfer(8'h66, 8'h66);
        exp_tx = exp_q.pop_front();
        n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL mid_echo got %h exp %h", obs_tx, exp_tx); end
        n_tests++; if (reg_of(1) !== 8'h66) begin n_fail++; $display("FAIL mid_reg1 got %h exp 66", reg_of(1)); end
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (bus_if.reg_out !== RST_REGS) begin n_fail++; $display("FAIL mid_rst_regs got %h exp %h", bus_if.reg_out, RST_REGS); end
        n_tests++; if (bus_if.err_count !== 8'h00) begin n_fail++; $display("FAIL mid_rst_err got %h exp 00", bus_if.err_count); end
        n_tests++; if (bus_if.tx_byte !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx got %h exp 00", bus_if.tx_byte); end
        n_tests++; if (bus_if.wr_addr !== 7'd0) begin n_fail++; $display("FAIL mid_rst_wr_addr got %h exp 00", bus_if.wr_addr); end
        frame_end();
        frame_start();
        xfer(8'h85, 8'h00);
        exp_tx = exp_q.pop_front();
        n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL post_cmd_tx got %h exp %h", obs_tx, exp_tx); end
        xfer(8'h3C, 8'h3C);
        exp_tx = exp_q.pop_front();
        n_tests++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL post_echo got %h exp %h", obs_tx, exp_tx); end
        n_tests++; if (obs_stb !== 1'b1) begin n_fail++; $display("FAIL post_stb got %b exp 1", obs_stb); end
        n_tests++; if (bus_if.wr_addr !== 7'd5) begin n_fail++; $display("FAIL post_wr_addr got %h exp 05", bus_if.wr_addr); end
        n_tests++; if (reg_of(5) !== 8'h3C) begin n_fail++; $display("FAIL post_reg5 got %h exp 3c", reg_of(5)); end
        frame_end();
    endtask

    initial begin
        exp_err = 8'h00;
        test_reset();
        test_burst_read();
        test_wrap_reg0();
        test_err_frame();
        test_frame_end_collision();
        test_rst_midburst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
